// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity/state types and baud divisor helper
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Rounded to the nearest whole clock so the bit-rate error stays below half a clock.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count and drop flag
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              do_wr, do_rd;

  assign full_o    = (cnt_q == LW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign level_o   = cnt_q;
  assign ovf_o     = ovf_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the write even if a pop frees a slot on the same edge.
  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = wr_en_i && full_o;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - FIFO-buffered UART transmitter with configurable framing
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 25_000_000,
  parameter int      BAUD      = 115200,
  parameter int      DATA_W    = 8,
  parameter int      DEPTH     = 16,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   tx_en,
  output logic                   ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   busy,
  output logic                   o_txp
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CNT_W    = $clog2(STOP_LEN + 1);
  localparam int BIT_W    = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              txp_q, txp_d;

  logic [DATA_W-1:0] rd_data;
  logic              baud_end, stop_end, pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level),
    .ovf_o     (ovf)
  );

  assign ready    = !full;
  assign busy     = (state_q != ST_IDLE);
  assign o_txp    = txp_q;
  assign baud_end = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign stop_end = (cnt_q == CNT_W'(STOP_LEN - 1));

  // Popping on the last stop-bit clock chains frames with no idle gap.
  assign pop = tx_en && !empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_end));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    case (state_q)
      ST_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (baud_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (baud_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (baud_end) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (stop_end) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    if (pop) begin
      state_d = ST_START;
      cnt_d   = '0;
      sh_d    = rd_data;
      par_d   = (^rd_data) ^ (PARITY == PAR_ODD);
    end
  end

  // Line is registered from the current state, so it trails the FSM by one clock.
  always_comb begin
    txp_d = 1'b1;
    case (state_q)
      ST_START:  txp_d = 1'b0;
      ST_DATA:   txp_d = sh_q[0];
      ST_PARITY: txp_d = par_q;
      default:   txp_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      txp_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      txp_q   <= txp_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb/tb_uart_tx_fifo_cfg.sv - randomized bench for uart_tx_fifo_cfg against a frame-level model
module tb_uart_tx_fifo_cfg;
  import uart_pkg::*;

  localparam int NDUT  = 4;
  localparam int DEPTH = 4;
  localparam int BD    = 10;
  localparam int LW    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic          ready_w [NDUT];
  logic          full_w  [NDUT];
  logic          empty_w [NDUT];
  logic          ovf_w   [NDUT];
  logic          busy_w  [NDUT];
  logic          txp_w   [NDUT];
  logic [LW-1:0] level_w [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rst_gen = 0;
  int peak_a = 0;
  int ovf_a = 0;
  int frames_seen [NDUT];

  logic [7:0] mq    [NDUT][$];
  logic [7:0] exp_d [NDUT][$];
  int         exp_s [NDUT][$];
  int         tfree [NDUT];
  logic       ovf_exp [NDUT];

  always #5 clk = ~clk;

  // instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  function automatic int par_of(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  function automatic int nbits(input int d);
    return 1 + 8 + ((par_of(d) != 0) ? 1 : 0) + ((d == 3) ? 2 : 1);
  endfunction

  function automatic logic [15:0] frame_bits(input int d, input logic [7:0] v);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = v[i];
    if (par_of(d) == 1) f[9] = ^v;
    else if (par_of(d) == 2) f[9] = ~(^v);
    return f;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input int d);
    mq[d].delete();
    exp_d[d].delete();
    exp_s[d].delete();
    tfree[d]   = 0;
    ovf_exp[d] = 1'b0;
  endtask

  // One clock edge of the frame-level model: the transmitter is free again
  // once a whole frame time has elapsed since its last pop.
  task automatic model_edge(input int d);
    int sz0;
    if (!rst_n) begin
      model_clear(d);
      return;
    end
    sz0        = mq[d].size();
    ovf_exp[d] = 1'b0;
    if (tx_en && sz0 > 0 && cyc >= tfree[d]) begin
      exp_d[d].push_back(mq[d].pop_front());
      exp_s[d].push_back(cyc + 1);
      tfree[d] = cyc + nbits(d) * BD;
    end
    if (wr_en) begin
      if (sz0 < DEPTH) mq[d].push_back(wr_data);
      else ovf_exp[d] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("level%0d", d), level_w[d], mq[d].size());
      check_eq($sformatf("full%0d", d),  full_w[d],  mq[d].size() == DEPTH);
      check_eq($sformatf("ready%0d", d), ready_w[d], mq[d].size() != DEPTH);
      check_eq($sformatf("empty%0d", d), empty_w[d], mq[d].size() == 0);
      check_eq($sformatf("busy%0d", d),  busy_w[d],  cyc < tfree[d]);
      check_eq($sformatf("ovf%0d", d),   ovf_w[d],   ovf_exp[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < NDUT; d++) model_edge(d);
    @(negedge clk);
    check_all();
    if (int'(level_w[0]) > peak_a) peak_a = int'(level_w[0]);
    if (ovf_w[0] === 1'b1) ovf_a++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [7:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  // Called at a falling edge; reset lands between clock edges.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rst_gen++;
    for (int d = 0; d < NDUT; d++) model_clear(d);
    #1;
    check_all();
    for (int d = 0; d < NDUT; d++) check_eq($sformatf("txp_rst%0d", d), txp_w[d], 1'b1);
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  task automatic mon_frame(input int d);
    int         g0, s, es, n;
    logic [7:0]  v;
    logic [15:0] f;
    @(negedge clk);
    if (txp_w[d] !== 1'b0) return;
    g0 = rst_gen;
    s  = cyc;
    n  = nbits(d);
    if (exp_s[d].size() == 0) begin
      check_eq($sformatf("spurious_frame%0d", d), 32'(exp_s[d].size()), 1);
      repeat (n * BD - 1) @(negedge clk);
      return;
    end
    es = exp_s[d].pop_front();
    v  = exp_d[d].pop_front();
    check_eq($sformatf("start%0d", d), s, es);
    f = frame_bits(d, v);
    for (int k = 0; k < n * BD; k++) begin
      if (k > 0) @(negedge clk);
      if (rst_gen != g0) return;
      if ((k % BD) == 0 || (k % BD) == BD - 1)
        check_eq($sformatf("line%0d_bit%0d", d, k / BD), txp_w[d], f[k/BD]);
    end
    frames_seen[d]++;
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam parity_e P = (g == 1) ? PAR_EVEN : (g == 2) ? PAR_ODD : PAR_NONE;
    localparam int      S = (g == 3) ? 2 : 1;

    uart_tx_fifo_cfg #(
      .CLK_FREQ  (1_000_000),
      .BAUD      (100_000),
      .DATA_W    (8),
      .DEPTH     (DEPTH),
      .PARITY    (P),
      .STOP_BITS (S)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .tx_en   (tx_en),
      .ready   (ready_w[g]),
      .full    (full_w[g]),
      .empty   (empty_w[g]),
      .level   (level_w[g]),
      .ovf     (ovf_w[g]),
      .busy    (busy_w[g]),
      .o_txp   (txp_w[g])
    );

    always mon_frame(g);
  end

  initial begin
    int f0 [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      model_clear(d);
      frames_seen[d] = 0;
    end

    tx_en = 1'b1;
    idle(3);
    for (int d = 0; d < NDUT; d++) check_eq($sformatf("txp_init%0d", d), txp_w[d], 1'b1);
    rst_n = 1'b1;

    write(8'h55);
    idle(130);
    check_eq("single_frames", frames_seen[0], 1);

    peak_a = 0;
    write(8'h55); write(8'hAA); write(8'h12); write(8'h34);
    idle(500);
    check_eq("burst_peak", peak_a, 3);
    check_eq("burst_frames", frames_seen[0], 5);

    tx_en = 1'b0;
    ovf_a = 0;
    for (int i = 0; i < 6; i++) write(8'(8'h60 + i));
    idle(1);
    check_eq("full_level", level_w[0], 4);
    check_eq("full_flag", full_w[0], 1'b1);
    check_eq("full_ready", ready_w[0], 1'b0);
    check_eq("ovf_pulses", ovf_a, 2);
    f0[0] = frames_seen[0];
    tx_en = 1'b1;
    idle(500);
    check_eq("drain_frames", frames_seen[0] - f0[0], 4);

    for (int d = 0; d < NDUT; d++) f0[d] = frames_seen[d];
    write(8'h07);
    idle(150);
    for (int d = 0; d < NDUT; d++) check_eq($sformatf("parity_frames%0d", d), frames_seen[d] - f0[d], 1);

    write(8'hC3); write(8'h3C);
    idle(2);
    tx_en = 1'b0;
    idle(200);
    check_eq("hold_level", level_w[0], 1);
    check_eq("hold_busy", busy_w[0], 1'b0);
    tx_en = 1'b1;
    step();
    check_eq("resume_busy", busy_w[0], 1'b1);
    idle(150);

    write(8'hA1); write(8'hB2); write(8'hC3);
    idle(125);
    async_reset(3);
    idle(250);

    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 39) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
      step();
      if ($urandom_range(0, 999) == 0) async_reset(2);
    end
    wr_en = 1'b0;
    tx_en = 1'b1;
    idle(700);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("unsent_frames%0d", d), 32'(exp_s[d].size()), 0);
      check_eq($sformatf("final_level%0d", d), level_w[d], 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
UART_TX_FIFO_CFG -- requirements
Module: uart_tx_fifo_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-004 SHALL have parameter DEPTH, default 16, FIFO entries, power of 2, at least 2.
REQ-005 SHALL have parameter PARITY, default PAR_NONE, parity mode from the shared package: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-006 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, 1 bit, write strobe.
REQ-010 SHALL have port wr_data, input, DATA_W bits, byte to send.
REQ-011 SHALL have port tx_en, input, 1 bit, transmit enable (start gate).
REQ-012 SHALL have port ready, output, 1 bit, equal to !full.
REQ-013 SHALL have port full, output, 1 bit, FIFO full.
REQ-014 SHALL have port empty, output, 1 bit, FIFO empty.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1 bits, current FIFO occupancy.
REQ-016 SHALL have port ovf, output, 1 bit, one-cycle pulse flagging a dropped write.
REQ-017 SHALL have port busy, output, 1 bit, high while a frame is on the line.
REQ-018 SHALL have port o_txp, output, 1 bit, serial line, idle high.

Function
REQ-019 SHALL derive BAUD_DIV = (CLK_FREQ + BAUD/2)/BAUD and hold every line bit for exactly BAUD_DIV clocks.
REQ-020 SHALL accept a write on a clock edge with wr_en=1 and full=0; level +1 unless a pop occurs on the same edge.
REQ-021 SHALL drop wr_en when full=1, leave FIFO contents unchanged and pulse ovf high for 1 cycle; simultaneous pop does not rescue the write.
REQ-022 SHALL pop when in IDLE (or on the last cycle of the final stop bit) with empty=0 and tx_en=1; pop plus write on the same edge leaves level unchanged.
REQ-023 SHALL use FSM states IDLE, START, DATA, PARITY, STOP: IDLE->START on pop; START->DATA after BAUD_DIV clocks; DATA->PARITY (PARITY!=PAR_NONE) or STOP after DATA_W bits; PARITY->STOP; STOP->START (pop) or IDLE after STOP_BITS*BAUD_DIV clocks.
REQ-024 SHALL drive o_txp as: START 0, DATA LSB first, PARITY = XOR of data bits (PAR_EVEN) or its inverse (PAR_ODD), STOP 1, IDLE 1.
REQ-025 SHALL make o_txp fall on the 2nd clock edge after the edge accepting a write into an empty FIFO in IDLE with tx_en=1.
REQ-026 SHALL send back-to-back frames with no idle gap when data is pending.
REQ-027 SHALL, when tx_en falls mid-frame, complete the current frame, then hold in IDLE.
REQ-028 SHALL assert busy in every state except IDLE.
REQ-029 SHALL keep full, empty, ready and level registered-consistent with occupancy on every cycle, with pointer wrap at DEPTH.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-frame, immediately force o_txp=1, busy=0, ovf=0, level=0, empty=1, full=0, ready=1, FSM=IDLE and FIFO pointers to 0.
REQ-031 SHALL resume normal operation on the first clock edge after rst_n rises.

Structure
REQ-032 SHALL take the parity enum and the BAUD_DIV computation function from shared package uart_pkg.
REQ-033 SHALL instantiate sub-module sync_fifo (DATA_W, DEPTH) for storage; framing FSM and baud counter stay in the top module.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10)
REQ-034 Single write 0x55, 8N1 -> o_txp low 2 cycles after the write edge, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then stop high; 100-clock frame, then busy=0 and empty=1.
REQ-035 Writes 0x55, 0xAA, 0x12, 0x34 on 4 consecutive edges -> 4 contiguous frames totalling 400 clocks, no idle cycle between them; level peaks at 3.
REQ-036 DEPTH=4, tx_en=0, 6 writes -> full=1 and ready=0 after the 4th, ovf pulses twice, level=4; then tx_en=1 -> exactly 4 frames.
REQ-037 Data 0x07 -> PAR_EVEN parity bit 1 and PAR_ODD parity bit 0 (110-clock frame); STOP_BITS=2 with PAR_NONE -> 110-clock frame.
REQ-038 rst_n low during DATA of the 2nd of 3 queued frames -> o_txp=1, level=0, empty=1 without waiting for a clock edge; no further frame after release.
REQ-039 tx_en falls during the START bit with 2 entries queued -> first frame completes, line idles, level=1; tx_en rises -> the next frame starts after 1 clock.
